// File: rtl/synchronous_fifo_reader_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
package synchronous_fifo_reader_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUFFER_DEPTH = 2;

endpackage

// File: rtl/synchronous_fifo_reader_stream_skid_buffer.sv
// Two-entry in-order word buffer: captures returning FIFO words at the tail, presents the head.
module stream_skid_buffer
    import synchronous_fifo_reader_package::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (count == 2'd0) head <= capture_data;
                    else               tail <= capture_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Capture and pop together: occupancy unchanged, words shift toward the head.
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= capture_data;
                    end else begin
                        head <= tail;
                        tail <= capture_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_data  = head;
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/synchronous_fifo_reader.sv
// Drains a registered-read synchronous FIFO into a ready/valid stream with enable/drain control.
module synchronous_fifo_reader
    import synchronous_fifo_reader_package::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    input  logic                   fifo_read_data_valid,
    output logic                   fifo_read_enable,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [1:0]             debug_state
);

    // Stream handshake: a word transfers on the rising clock edge where m_valid && m_ready;
    // once m_valid is high it stays high and m_data stays stable until that transfer.

    state_t     state;
    state_t     state_next;
    logic       in_flight;
    logic       pop;
    logic       capture;
    logic [1:0] count;
    logic [2:0] occupancy;

    assign pop       = m_valid && m_ready;
    assign capture   = in_flight && fifo_read_data_valid;
    // Words held or owed after this cycle's pop; a new read must keep this below the buffer depth.
    assign occupancy = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};

    always_comb begin
        state_next       = state;
        fifo_read_enable = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                fifo_read_enable = enable && !fifo_empty && (occupancy < 3'(BUFFER_DEPTH));
                if (!enable) state_next = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (!in_flight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            in_flight  <= 1'b0;
            word_count <= '0;
        end else begin
            state     <= state_next;
            in_flight <= fifo_read_enable;
            if (pop) word_count <= word_count + 1'b1;
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clock        (clock),
        .reset        (reset),
        .capture      (capture),
        .capture_data (fifo_read_data),
        .pop          (pop),
        .head_data    (m_data),
        .head_valid   (m_valid),
        .count        (count)
    );

    assign busy        = (state != IDLE);
    assign debug_state = state;

endmodule

// File: tb/tb_synchronous_fifo_reader.sv
// Directed bench: cycle table for back-to-back streaming, hand sequences for the multi-cycle corners.
module tb_synchronous_fifo_reader;
    import synchronous_fifo_reader_package::*;

    localparam int   DW = 16;
    localparam logic H  = 1'b1;
    localparam logic L  = 1'b0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_read_data = '0;
    logic          fifo_read_data_valid = 1'b0;
    logic          fifo_read_enable;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          busy;
    logic [31:0]   word_count;
    logic [1:0]    debug_state;
    logic          fifo_read_enable_4;
    logic [DW-1:0] m_data_4;
    logic          m_valid_4;
    logic          busy_4;
    logic [3:0]    word_count_4;
    logic [1:0]    debug_state_4;

    int compared = 0;
    int mismatched = 0;
    int reads_issued = 0;
    logic [31:0]   exp_wc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];

    typedef struct {
        logic        en;
        logic        rdy;
        logic        re;
        logic        mv;
        logic [15:0] data;
        logic        busy;
        logic [1:0]  st;
        logic [31:0] wc;
    } vec_t;
    vec_t vecs[12];

    always #5 clock = ~clock;

    synchronous_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(32)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_read_data_valid(fifo_read_data_valid),
        .fifo_read_enable(fifo_read_enable), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .word_count(word_count), .debug_state(debug_state)
    );

    // Narrow-counter twin sees identical inputs, so it tracks u_dut word for word.
    synchronous_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) u_dut_4 (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_read_data_valid(fifo_read_data_valid),
        .fifo_read_enable(fifo_read_enable_4), .m_data(m_data_4), .m_valid(m_valid_4),
        .m_ready(m_ready), .busy(busy_4), .word_count(word_count_4), .debug_state(debug_state_4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(first + DW'(i));
            exp_q.push_back(first + DW'(i));
        end
    endtask

    // Apply inputs at the falling edge, then run the scoreboard and contract monitors.
    task automatic drive(input logic en, input logic rdy, input logic rst);
        logic [DW-1:0] e;
        logic [2:0]    occ;
        @(negedge clock);
        enable  = en;
        m_ready = rdy;
        reset   = rst;
        #1;
        if (fifo_read_enable === 1'b1) reads_issued++;
        if (!rst && m_valid === 1'b1 && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(m_data), 32'(e));
                check("sb_data_w4", 32'(m_data_4), 32'(e));
            end
            exp_wc++;
        end
        if (u_dut.in_flight === 1'b1) begin
            check("rd_valid_on_return", 32'(fifo_read_data_valid), 32'd1);
            check("capture_into_full", 32'(u_dut.count == 2'd2), 32'd0);
        end
        occ = {1'b0, u_dut.count} + {2'b00, u_dut.in_flight} - {2'b00, (m_valid & m_ready)};
        if (occ >= 3'd2) check("issue_while_full", 32'(fifo_read_enable), 32'd0);
    endtask

    // Cross the rising edge, then update the FIFO model as a registered-read FIFO would.
    task automatic advance();
        logic issue;
        logic rst;
        issue = fifo_read_enable;
        rst   = reset;
        @(posedge clock);
        #1;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            exp_wc = 0;
            fifo_read_data_valid = 1'b0;
        end else if (issue) begin
            if (fifo_q.size() == 0) begin
                check("fifo_underflow", 32'd1, 32'd0);
                fifo_read_data_valid = 1'b0;
            end else begin
                fifo_read_data = fifo_q.pop_front();
                fifo_read_data_valid = 1'b1;
            end
        end else begin
            fifo_read_data_valid = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic step(input logic en, input logic rdy, input logic rst);
        drive(en, rdy, rst);
        advance();
    endtask

    initial begin
        vecs[0]  = '{H, H, L, L, 16'h0000, L, IDLE, 32'd0};
        vecs[1]  = '{H, H, H, L, 16'h0000, H, RUN,  32'd0};
        vecs[2]  = '{H, H, H, L, 16'h0000, H, RUN,  32'd0};
        vecs[3]  = '{H, H, H, H, 16'h0001, H, RUN,  32'd0};
        vecs[4]  = '{H, H, H, H, 16'h0002, H, RUN,  32'd1};
        vecs[5]  = '{H, H, H, H, 16'h0003, H, RUN,  32'd2};
        vecs[6]  = '{H, H, H, H, 16'h0004, H, RUN,  32'd3};
        vecs[7]  = '{H, H, H, H, 16'h0005, H, RUN,  32'd4};
        vecs[8]  = '{H, H, H, H, 16'h0006, H, RUN,  32'd5};
        vecs[9]  = '{H, H, L, H, 16'h0007, H, RUN,  32'd6};
        vecs[10] = '{H, H, L, H, 16'h0008, H, RUN,  32'd7};
        vecs[11] = '{H, H, L, L, 16'h0000, H, RUN,  32'd8};

        // Reset state
        step(L, L, H);
        drive(L, L, H);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_state", 32'(debug_state), 32'(IDLE));
        check("rst_read_enable", 32'(fifo_read_enable), 32'd0);
        check("rst_count", 32'(u_dut.count), 32'd0);
        check("rst_in_flight", 32'(u_dut.in_flight), 32'd0);
        advance();

        // Back-to-back stream from the cycle table
        preload(16'h0001, 8);
        step(L, L, L);
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].rdy, L);
            check($sformatf("vec%0d_read_enable", i), 32'(fifo_read_enable), 32'(vecs[i].re));
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
            if (vecs[i].mv) check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_state", i), 32'(debug_state), 32'(vecs[i].st));
            check($sformatf("vec%0d_word_count", i), word_count, vecs[i].wc);
            advance();
        end

        // Backpressure with m_ready pattern 1,0,0,1
        preload(16'h0010, 6);
        for (int i = 0; i < 40; i++) step(H, ((i % 4) == 0) || ((i % 4) == 3), L);
        drive(H, L, L);
        check("bp_leftover", 32'(exp_q.size()), 32'd0);
        check("bp_word_count", word_count, exp_wc);
        advance();

        // Stall with the buffer full
        preload(16'h0020, 4);
        reads_issued = 0;
        for (int i = 0; i < 10; i++) begin
            drive(H, L, L);
            if (m_valid === 1'b1) check("stall_head_data", 32'(m_data), 32'h0020);
            advance();
        end
        drive(H, L, L);
        check("stall_reads", reads_issued, 32'd2);
        check("stall_count", 32'(u_dut.count), 32'd2);
        check("stall_read_enable", 32'(fifo_read_enable), 32'd0);
        check("stall_m_valid", 32'(m_valid), 32'd1);
        advance();
        for (int i = 0; i < 10; i++) step(H, H, L);
        check("stall_leftover", 32'(exp_q.size()), 32'd0);

        // Drain with one word buffered and one in flight
        preload(16'h0030, 6);
        for (int i = 0; i < 4; i++) step(H, H, L);
        drive(L, H, L);
        check("drain_buffered", 32'(u_dut.count), 32'd1);
        check("drain_in_flight", 32'(u_dut.in_flight), 32'd1);
        check("drain_read_enable0", 32'(fifo_read_enable), 32'd0);
        advance();
        drive(L, H, L);
        check("drain_state", 32'(debug_state), 32'(DRAIN));
        check("drain_read_enable1", 32'(fifo_read_enable), 32'd0);
        check("drain_m_valid", 32'(m_valid), 32'd1);
        advance();
        drive(L, H, L);
        check("drain_idle_state", 32'(debug_state), 32'(IDLE));
        check("drain_idle_busy", 32'(busy), 32'd0);
        check("drain_idle_m_valid", 32'(m_valid), 32'd0);
        check("drain_left_in_fifo", 32'(exp_q.size()), 32'd3);
        advance();

        // Re-enable while draining
        drive(H, H, L);
        check("reen_idle_read_enable", 32'(fifo_read_enable), 32'd0);
        advance();
        step(H, H, L);
        step(H, H, L);
        drive(L, H, L);
        check("reen_drop_read_enable", 32'(fifo_read_enable), 32'd0);
        advance();
        drive(H, H, L);
        check("reen_drain_state", 32'(debug_state), 32'(DRAIN));
        check("reen_drain_read_enable", 32'(fifo_read_enable), 32'd0);
        advance();
        drive(H, H, L);
        check("reen_run_state", 32'(debug_state), 32'(RUN));
        check("reen_run_read_enable", 32'(fifo_read_enable), 32'd1);
        advance();
        for (int i = 0; i < 5; i++) step(H, H, L);
        check("reen_leftover", 32'(exp_q.size()), 32'd0);
        check("reen_word_count", word_count, exp_wc);

        // Reset mid-stream with two words buffered
        preload(16'h0040, 4);
        for (int i = 0; i < 6; i++) step(H, L, L);
        drive(H, L, L);
        check("mid_rst_pre_count", 32'(u_dut.count), 32'd2);
        check("mid_rst_pre_m_valid", 32'(m_valid), 32'd1);
        advance();
        step(H, L, H);
        drive(H, L, L);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_word_count", word_count, 32'd0);
        check("mid_rst_state", 32'(debug_state), 32'(IDLE));
        check("mid_rst_read_enable", 32'(fifo_read_enable), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // Counter wrap on the 4-bit twin
        preload(16'h0100, 17);
        advance();
        for (int i = 0; i < 25; i++) step(H, H, L);
        drive(H, H, L);
        check("wrap_word_count", word_count, 32'd17);
        check("wrap_word_count_4", 32'(word_count_4), 32'd1);
        check("wrap_m_valid_4", 32'(m_valid_4), 32'd0);
        check("wrap_busy_4", 32'(busy_4), 32'd1);
        check("wrap_read_enable_4", 32'(fifo_read_enable_4), 32'd0);
        check("wrap_state_4", 32'(debug_state_4), 32'(RUN));
        check("wrap_leftover", 32'(exp_q.size()), 32'd0);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
